board_shadow_ram: RTL

- Double-buffered 16-entry tile-index store for the 4x4 board. It sits directly upstream of the VGA pixel generator and drives that generator's shadow RAM read interface.
- Game logic writes tile updates into a back bank. A commit request swaps banks only at the start of the vertical sync pulse, so a board update never tears mid-frame.
- After each swap, the new back bank is resynchronised from the new front bank so that later partial updates start from the displayed board.

---
 rtl/board_shadow_ram.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/board_shadow_ram.sv
// Double-buffered 4x4 board tile store feeding the VGA pixel generator.
// Game writes land in the back bank; a commit swaps banks at the start of
// the vsync pulse and then resynchronises the new back bank from the new
// front bank so later partial updates start from the displayed board.
module board_shadow_ram #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 5,
  parameter int INIT_SOLVED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit_req,
  output logic              commit_busy,
  output logic              commit_done,
  input  logic              vga_vs,
  input  logic [ADDR_W-1:0] shadow_ram_raddr,
  output logic [DATA_W-1:0] shadow_ram_rdata
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    COPY    = 2'd2
  } state_t;

  // Reset content of a cell: solved board (1..15, hole in the last cell) or empty.
  function automatic logic [DATA_W-1:0] init_val(input int idx);
    if (INIT_SOLVED == 0) begin
      return {DATA_W{1'b0}};
    end else if (idx == DEPTH - 1) begin
      return {DATA_W{1'b0}};
    end else begin
      return DATA_W'(idx + 1);
    end
  endfunction

  logic [DATA_W-1:0] bank_r [2][DEPTH];
  state_t            state_r;
  state_t            state_nxt_s;
  logic              front_sel_r;
  logic              back_sel_s;
  logic              vs_d_r;
  logic              vs_fall_s;
  logic [ADDR_W-1:0] copy_idx_r;
  logic              wr_ready_r;
  logic              commit_busy_r;
  logic              commit_done_r;
  logic              wr_en_s;
  logic              copy_en_s;
  logic              swap_s;
  logic              done_nxt_s;

  assign back_sel_s       = ~front_sel_r;
  assign vs_fall_s        = vs_d_r & ~vga_vs;
  assign wr_ready         = wr_ready_r;
  assign commit_busy      = commit_busy_r;
  assign commit_done      = commit_done_r;
  // The display side only ever sees the front bank, with no read latency.
  assign shadow_ram_rdata = bank_r[front_sel_r][shadow_ram_raddr];

  // Next-state and per-cycle strobes of the commit FSM.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    copy_en_s   = 1'b0;
    swap_s      = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        wr_en_s = wr_valid & wr_ready_r;
        // A vsync fall in the acceptance cycle is deliberately ignored here.
        if (commit_req) begin
          state_nxt_s = WAIT_VS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_VS: begin
        if (vs_fall_s) begin
          swap_s      = 1'b1;
          state_nxt_s = COPY;
        end else begin
          state_nxt_s = WAIT_VS;
        end
      end
      COPY: begin
        copy_en_s = 1'b1;
        if (copy_idx_r == LAST_IDX) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = COPY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, bank select, vsync history, copy pointer and registered handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      front_sel_r   <= 1'b0;
      vs_d_r        <= 1'b1;
      copy_idx_r    <= {ADDR_W{1'b0}};
      wr_ready_r    <= 1'b0;
      commit_busy_r <= 1'b0;
      commit_done_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      vs_d_r        <= vga_vs;
      wr_ready_r    <= (state_nxt_s == IDLE);
      commit_busy_r <= (state_nxt_s != IDLE);
      commit_done_r <= done_nxt_s;
      if (swap_s) begin
        front_sel_r <= ~front_sel_r;
        copy_idx_r  <= {ADDR_W{1'b0}};
      end else if (copy_en_s) begin
        copy_idx_r  <= copy_idx_r + ADDR_W'(1);
      end
    end
  end

  // Bank storage: game writes and post-swap resync both target the back bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_r[b][i] <= init_val(i);
        end
      end
    end else if (wr_en_s) begin
      bank_r[back_sel_s][wr_addr] <= wr_data;
    end else if (copy_en_s) begin
      bank_r[back_sel_s][copy_idx_r] <= bank_r[front_sel_r][copy_idx_r];
    end
  end

endmodule
